grf_bypass_log: RTL

//  General register file at the write-back end of the p5 pipeline: consumes Wd/A3/RegWrite

---
 rtl/grf_bypass_log.sv | 104 ++++++++++
 1 files changed

// File: rtl/grf_bypass_log.sv
// Register file for the write-back end of the pipeline, with same-cycle write-through bypass
// onto both read ports and a valid/ready commit-log FIFO that records every register write.
module grf_bypass_log #(
    parameter int LOG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  A3,
    input  logic [31:0] Wd,
    input  logic [31:0] WPC,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_pc,
    output logic [4:0]  log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow
);

    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int CNT_W = $clog2(LOG_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LOG_DEPTH);

    logic [31:0]      r_regs    [32];
    logic [31:0]      r_fifo_pc [LOG_DEPTH];
    logic [4:0]       r_fifo_ad [LOG_DEPTH];
    logic [31:0]      r_fifo_dt [LOG_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_commit;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_commit = RegWrite && (A3 != 5'd0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_pop    = (r_count != '0) && log_ready;
    // A full FIFO can still take a commit if the head leaves on the same edge.
    assign w_push   = w_commit && (!w_full || w_pop);
    assign w_drop   = w_commit && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[A3] <= Wd;
        end
    end

    // Log storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr] <= WPC;
            r_fifo_ad[r_wr_ptr] <= A3;
            r_fifo_dt[r_wr_ptr] <= Wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign RD1 = (A1 == 5'd0)            ? 32'd0 :
                 (w_commit && (A3 == A1)) ? Wd    : r_regs[A1];
    assign RD2 = (A2 == 5'd0)            ? 32'd0 :
                 (w_commit && (A3 == A2)) ? Wd    : r_regs[A2];

    assign log_valid    = (r_count != '0);
    assign log_pc       = log_valid ? r_fifo_pc[r_rd_ptr] : 32'd0;
    assign log_addr     = log_valid ? r_fifo_ad[r_rd_ptr] : 5'd0;
    assign log_data     = log_valid ? r_fifo_dt[r_rd_ptr] : 32'd0;
    assign log_overflow = r_overflow;

endmodule
